// File: rtl/run_length_reporter_pkg.sv
// -----------------------------------------------------------------------------
// run_length_reporter_pkg
//   Shared definitions for the run-length reporter: the FSM state encoding and
//   the default widths and minimum reported run length.
// -----------------------------------------------------------------------------
package run_length_reporter_pkg;

    // IDLE: waiting for z to rise. RUN: counting the cycles z stays high.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_LEN_W   = 8;   // run-length counter / rpt_len width
    localparam int DEF_CNT_W   = 16;  // completed-run counter width
    localparam int DEF_MIN_LEN = 1;   // shortest run that is reported

endpackage

// File: rtl/run_length_reporter_if.sv
// -----------------------------------------------------------------------------
// run_length_reporter_if
//   Valid/ready report channel from the reporter to the next stage.
//   rpt_valid : report slot holds an unaccepted length (master drives)
//   rpt_len   : reported run length in cycles         (master drives)
//   rpt_ready : consumer accepts rpt_len this cycle   (slave drives)
// -----------------------------------------------------------------------------
interface run_length_reporter_if
    import run_length_reporter_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
);

    logic             rpt_valid;
    logic             rpt_ready;
    logic [LEN_W-1:0] rpt_len;

    modport master (output rpt_valid, output rpt_len, input  rpt_ready);
    modport slave  (input  rpt_valid, input  rpt_len, output rpt_ready);

endinterface

// File: rtl/run_length_reporter_sat_counter.sv
// -----------------------------------------------------------------------------
// run_length_reporter_sat_counter
//   Saturating up-counter with synchronous clear and load-of-one.
//   clock : clock, all updates on posedge
//   rst   : asynchronous active-high reset, q -> 0
//   clr   : synchronous clear; an inc in the same cycle still counts (q -> 1)
//   load1 : restart the count at 1
//   inc   : increment, holding at all-ones
//   q     : count value
// -----------------------------------------------------------------------------
module run_length_reporter_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_V = '1;
    localparam logic [W-1:0] ONE_V = W'(1);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            // Clear first, then apply this cycle's increment.
            q <= inc ? ONE_V : '0;
        end else if (load1) begin
            q <= ONE_V;
        end else if (inc && (q != MAX_V)) begin
            q <= q + ONE_V;
        end
    end

endmodule

// File: rtl/run_length_reporter.sv
// -----------------------------------------------------------------------------
// run_length_reporter
//   Measures how many cycles each z-high episode lasts, counts completed runs
//   of at least MIN_LEN cycles, and offers each length through a single-entry
//   valid/ready slot. A completion that finds the slot full is dropped and
//   sets the sticky overrun flag.
//   clock     : clock, all updates on posedge
//   rst       : asynchronous active-high reset
//   z_in      : run detector level output
//   clr       : synchronous clear of run_count and overrun (clear-then-apply)
//   rpt       : report channel (master side): rpt_valid, rpt_len, rpt_ready
//   run_count : completed runs with length >= MIN_LEN, saturating
//   overrun   : sticky, a report was dropped because the slot was full
//   active    : a run is currently being measured
// -----------------------------------------------------------------------------
module run_length_reporter
    import run_length_reporter_pkg::*;
#(
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MIN_LEN = DEF_MIN_LEN
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   z_in,
    input  logic                   clr,
    run_length_reporter_if.master  rpt,
    output logic [CNT_W-1:0]       run_count,
    output logic                   overrun,
    output logic                   active
);

    localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);

    state_t           state, next_state;
    logic             len_load1, len_inc, run_end;
    logic [LEN_W-1:0] len_q;
    logic             counted, slot_free, drop;
    logic             valid_q, overrun_q;
    logic [LEN_W-1:0] rpt_len_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        len_load1  = 1'b0;
        len_inc    = 1'b0;
        run_end    = 1'b0;
        unique case (state)
            IDLE: begin
                if (z_in) begin
                    next_state = RUN;
                    len_load1  = 1'b1;
                end
            end
            RUN: begin
                if (z_in) begin
                    len_inc = 1'b1;
                end else begin
                    next_state = IDLE;
                    run_end    = 1'b1;
                end
            end
        endcase
    end

    run_length_reporter_sat_counter #(.W(LEN_W)) u_len (
        .clock (clock),
        .rst   (rst),
        .clr   (1'b0),
        .load1 (len_load1),
        .inc   (len_inc),
        .q     (len_q)
    );

    // A run ends on the first 0 sample; only runs of MIN_LEN or more count.
    assign counted = run_end && (len_q >= MIN_LEN_V);

    run_length_reporter_sat_counter #(.W(CNT_W)) u_run_count (
        .clock (clock),
        .rst   (rst),
        .clr   (clr),
        .load1 (1'b0),
        .inc   (counted),
        .q     (run_count)
    );

    // The slot is free if empty or being drained at this very edge.
    assign slot_free = !valid_q || rpt.rpt_ready;
    assign drop      = counted && !slot_free;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rpt_len_q <= '0;
        end else if (counted && slot_free) begin
            valid_q   <= 1'b1;
            rpt_len_q <= len_q;
        end else if (valid_q && rpt.rpt_ready) begin
            valid_q   <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst)       overrun_q <= 1'b0;
        else if (clr)  overrun_q <= drop;
        else if (drop) overrun_q <= 1'b1;
    end

    assign rpt.rpt_valid = valid_q;
    assign rpt.rpt_len   = rpt_len_q;
    assign overrun       = overrun_q;
    assign active        = (state == RUN);

endmodule

// File: tb/tb_run_length_reporter.sv
// -----------------------------------------------------------------------------
// tb_run_length_reporter
//   Three reporter instances: A (defaults), B (LEN_W=3, CNT_W=2) and
//   C (MIN_LEN=2). Directed stimulus pushes expected lengths into per-instance
//   queues; monitors pop and compare on every accepted report.
// -----------------------------------------------------------------------------
module tb_run_length_reporter;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    logic z_a = 1'b0, clr_a = 1'b0;
    logic z_b = 1'b0, clr_b = 1'b0;
    logic z_c = 1'b0, clr_c = 1'b0;

    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [15:0] cnt_c;
    logic        ovr_a, ovr_b, ovr_c;
    logic        act_a, act_b, act_c;

    int errors = 0;
    int checks = 0;

    int exp_a[$];
    int exp_b[$];
    int exp_c[$];

    run_length_reporter_if #(.LEN_W(8)) if_a ();
    run_length_reporter_if #(.LEN_W(3)) if_b ();
    run_length_reporter_if #(.LEN_W(8)) if_c ();

    run_length_reporter #(.LEN_W(8), .CNT_W(16), .MIN_LEN(1)) dut_a (
        .clock (clock), .rst (rst), .z_in (z_a), .clr (clr_a), .rpt (if_a.master),
        .run_count (cnt_a), .overrun (ovr_a), .active (act_a)
    );
    run_length_reporter #(.LEN_W(3), .CNT_W(2), .MIN_LEN(1)) dut_b (
        .clock (clock), .rst (rst), .z_in (z_b), .clr (clr_b), .rpt (if_b.master),
        .run_count (cnt_b), .overrun (ovr_b), .active (act_b)
    );
    run_length_reporter #(.LEN_W(8), .CNT_W(16), .MIN_LEN(2)) dut_c (
        .clock (clock), .rst (rst), .z_in (z_c), .clr (clr_c), .rpt (if_c.master),
        .run_count (cnt_c), .overrun (ovr_c), .active (act_c)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Inputs change and direct checks happen 1 time unit after the posedge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitors: a transfer happens at the next posedge when valid&ready at negedge.
    always @(negedge clock) begin
        if (!rst && if_a.rpt_valid && if_a.rpt_ready) begin
            if (exp_a.size() == 0) check("a_unexpected_report", int'(if_a.rpt_len), -1);
            else                   check("a_rpt_len", int'(if_a.rpt_len), exp_a.pop_front());
        end
    end
    always @(negedge clock) begin
        if (!rst && if_b.rpt_valid && if_b.rpt_ready) begin
            if (exp_b.size() == 0) check("b_unexpected_report", int'(if_b.rpt_len), -1);
            else                   check("b_rpt_len", int'(if_b.rpt_len), exp_b.pop_front());
        end
    end
    always @(negedge clock) begin
        if (!rst && if_c.rpt_valid && if_c.rpt_ready) begin
            if (exp_c.size() == 0) check("c_unexpected_report", int'(if_c.rpt_len), -1);
            else                   check("c_rpt_len", int'(if_c.rpt_len), exp_c.pop_front());
        end
    end

    initial begin
        if_a.rpt_ready = 1'b0;
        if_b.rpt_ready = 1'b0;
        if_c.rpt_ready = 1'b0;

        // 1: reset held while z toggles
        for (int i = 0; i < 4; i++) begin
            z_a = ~z_a;
            step();
        end
        check("rst_a_valid",   int'(if_a.rpt_valid), 0);
        check("rst_a_len",     int'(if_a.rpt_len),   0);
        check("rst_a_count",   int'(cnt_a),          0);
        check("rst_a_overrun", int'(ovr_a),          0);
        check("rst_a_active",  int'(act_a),          0);
        z_a = 1'b0;
        rst = 1'b0;
        step();

        // 2: 3-cycle run, consumer ready
        if_a.rpt_ready = 1'b1;
        exp_a.push_back(3);
        z_a = 1'b1;
        step();
        check("s2_active_start", int'(act_a), 1);
        step(2);
        z_a = 1'b0;
        step();
        check("s2_valid",   int'(if_a.rpt_valid), 1);
        check("s2_len",     int'(if_a.rpt_len),   3);
        check("s2_count",   int'(cnt_a),          1);
        check("s2_overrun", int'(ovr_a),          0);
        check("s2_active_end", int'(act_a),       0);
        step();
        check("s2_valid_drop", int'(if_a.rpt_valid), 0);

        // 3: stalled consumer, second report dropped
        if_a.rpt_ready = 1'b0;
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check("s3_clr_count", int'(cnt_a), 0);
        exp_a.push_back(2);
        z_a = 1'b1;
        step(2);
        z_a = 1'b0;
        step(2);
        z_a = 1'b1;
        step(5);
        z_a = 1'b0;
        step();
        check("s3_len_held", int'(if_a.rpt_len),   2);
        check("s3_valid",    int'(if_a.rpt_valid), 1);
        check("s3_overrun",  int'(ovr_a),          1);
        check("s3_count",    int'(cnt_a),          2);
        if_a.rpt_ready = 1'b1;
        step();
        check("s3_drain", int'(if_a.rpt_valid), 0);

        // 4: slot drained on the same edge a new run completes
        if_a.rpt_ready = 1'b0;
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check("s4_clr_overrun", int'(ovr_a), 0);
        exp_a.push_back(2);
        exp_a.push_back(4);
        z_a = 1'b1;
        step(2);
        z_a = 1'b0;
        step();
        z_a = 1'b1;
        step(4);
        z_a = 1'b0;
        if_a.rpt_ready = 1'b1;
        step();
        check("s4_len",     int'(if_a.rpt_len),   4);
        check("s4_valid",   int'(if_a.rpt_valid), 1);
        check("s4_overrun", int'(ovr_a),          0);
        step();
        if_a.rpt_ready = 1'b0;

        // 1b: asynchronous reset between edges, report pending and run active
        z_a = 1'b1;
        step();
        z_a = 1'b0;
        step();
        z_a = 1'b1;
        step();
        check("arst_pre_valid",  int'(if_a.rpt_valid), 1);
        check("arst_pre_active", int'(act_a),          1);
        #1 rst = 1'b1;
        #1;
        check("arst_valid",  int'(if_a.rpt_valid), 0);
        check("arst_len",    int'(if_a.rpt_len),   0);
        check("arst_count",  int'(cnt_a),          0);
        check("arst_active", int'(act_a),          0);
        z_a = 1'b0;
        #1 rst = 1'b0;
        step();

        // 5: narrow counters saturate; clr together with a completion
        if_b.rpt_ready = 1'b1;
        exp_b.push_back(7);
        z_b = 1'b1;
        step(10);
        z_b = 1'b0;
        step();
        check("s5_len_sat", int'(if_b.rpt_len), 7);
        check("s5_count1",  int'(cnt_b),        1);
        for (int i = 0; i < 4; i++) begin
            exp_b.push_back(1);
            z_b = 1'b1;
            step();
            z_b = 1'b0;
            step();
        end
        check("s5_count_sat", int'(cnt_b), 3);
        exp_b.push_back(1);
        z_b = 1'b1;
        step();
        z_b = 1'b0;
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        check("s5_clr_completion", int'(cnt_b), 1);
        check("s5_clr_valid", int'(if_b.rpt_valid), 1);
        step();

        // 6: MIN_LEN=2, short run ignored; reset mid-run
        if_c.rpt_ready = 1'b1;
        z_c = 1'b1;
        step();
        z_c = 1'b0;
        step();
        check("s6_short_valid", int'(if_c.rpt_valid), 0);
        check("s6_short_count", int'(cnt_c),          0);
        z_c = 1'b1;
        step(4);
        check("s6_active_pre", int'(act_c), 1);
        #1 rst = 1'b1;
        #1;
        check("s6_active_rst", int'(act_c),          0);
        check("s6_valid_rst",  int'(if_c.rpt_valid), 0);
        #1 rst = 1'b0;
        exp_c.push_back(2);
        step(2);
        z_c = 1'b0;
        step();
        check("s6_len",   int'(if_c.rpt_len),   2);
        check("s6_valid", int'(if_c.rpt_valid), 1);
        check("s6_count", int'(cnt_c),          1);
        step(3);

        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        check("c_queue_drained", exp_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
